// File: rtl/tsc_pkg.sv
// Shared definitions for the TSC multicycle control path.
// Holds opcode/function-field constants, ALU function codes, the control FSM
// state enumeration, the decoded instruction classes and the mux-select
// encodings driven onto the datapath.
package tsc_pkg;

  // Primary opcodes
  localparam int unsigned OpBne   = 0;
  localparam int unsigned OpBeq   = 1;
  localparam int unsigned OpBgz   = 2;
  localparam int unsigned OpBlz   = 3;
  localparam int unsigned OpAdi   = 4;
  localparam int unsigned OpOri   = 5;
  localparam int unsigned OpLhi   = 6;
  localparam int unsigned OpLwd   = 7;
  localparam int unsigned OpSwd   = 8;
  localparam int unsigned OpJmp   = 9;
  localparam int unsigned OpJal   = 10;
  localparam int unsigned OpRtype = 15;

  // R-format function field values
  localparam int unsigned FnAdd = 0;
  localparam int unsigned FnSub = 1;
  localparam int unsigned FnAnd = 2;
  localparam int unsigned FnOrr = 3;
  localparam int unsigned FnNot = 4;
  localparam int unsigned FnTcp = 5;
  localparam int unsigned FnShl = 6;
  localparam int unsigned FnShr = 7;
  localparam int unsigned FnJpr = 25;
  localparam int unsigned FnJrl = 26;
  localparam int unsigned FnWwd = 28;
  localparam int unsigned FnHlt = 29;
  localparam int unsigned FnEni = 30;
  localparam int unsigned FnDsi = 31;

  // ALU function codes
  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOrr = 3'd3;
  localparam logic [2:0] AluNot = 3'd4;
  localparam logic [2:0] AluTcp = 3'd5;
  localparam logic [2:0] AluShl = 3'd6;
  localparam logic [2:0] AluShr = 3'd7;

  // pc_src select
  localparam logic [1:0] PcSrcNext   = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;  // immediate jump or register target
  localparam logic [1:0] PcSrcVector = 2'd3;

  // reg_dst select
  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstR2 = 2'd2;

  // mem_to_reg select
  localparam logic [1:0] MemToRegAlu = 2'd0;
  localparam logic [1:0] MemToRegMem = 2'd1;
  localparam logic [1:0] MemToRegPc  = 2'd2;

  // alu_src_b select
  localparam logic [1:0] AluSrcBReg = 2'd0;
  localparam logic [1:0] AluSrcBImm = 2'd1;
  localparam logic [1:0] AluSrcBOne = 2'd2;

  typedef enum logic [2:0] {
    StIf, StId, StEx, StMem, StWb, StInt, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClNop, ClRalu, ClIalu, ClLoad, ClStore, ClBranch, ClJmp,
    ClJal, ClJpr, ClJrl, ClWwd, ClHlt, ClEni, ClDsi
  } iclass_e;

  // Classes whose ALU second operand is the sign/zero-extended immediate.
  function automatic logic uses_imm(iclass_e c);
    return (c == ClIalu) || (c == ClLoad) || (c == ClStore);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction classifier.
// Ports:
//   opcode  in  instruction opcode field
//   func    in  R-format function field
//   iclass  out decoded instruction class (unknown encodings -> ClNop)
//   alu_op  out ALU function used in the execute step
module control_decode
  import tsc_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned FUNC_W   = 6,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  output iclass_e             iclass,
  output logic [ALUOP_W-1:0]  alu_op
);

  logic [2:0] alu_code;

  always_comb begin
    iclass   = ClNop;
    alu_code = AluAdd;
    case (opcode)
      OPCODE_W'(OpBne), OPCODE_W'(OpBeq), OPCODE_W'(OpBgz), OPCODE_W'(OpBlz): begin
        iclass   = ClBranch;
        alu_code = AluSub;
      end
      OPCODE_W'(OpAdi): iclass = ClIalu;
      OPCODE_W'(OpOri): begin
        iclass   = ClIalu;
        alu_code = AluOrr;
      end
      OPCODE_W'(OpLhi): begin
        iclass   = ClIalu;
        alu_code = AluShl;
      end
      OPCODE_W'(OpLwd): iclass = ClLoad;
      OPCODE_W'(OpSwd): iclass = ClStore;
      OPCODE_W'(OpJmp): iclass = ClJmp;
      OPCODE_W'(OpJal): iclass = ClJal;
      OPCODE_W'(OpRtype): begin
        case (func)
          FUNC_W'(FnAdd): begin iclass = ClRalu; alu_code = AluAdd; end
          FUNC_W'(FnSub): begin iclass = ClRalu; alu_code = AluSub; end
          FUNC_W'(FnAnd): begin iclass = ClRalu; alu_code = AluAnd; end
          FUNC_W'(FnOrr): begin iclass = ClRalu; alu_code = AluOrr; end
          FUNC_W'(FnNot): begin iclass = ClRalu; alu_code = AluNot; end
          FUNC_W'(FnTcp): begin iclass = ClRalu; alu_code = AluTcp; end
          FUNC_W'(FnShl): begin iclass = ClRalu; alu_code = AluShl; end
          FUNC_W'(FnShr): begin iclass = ClRalu; alu_code = AluShr; end
          FUNC_W'(FnJpr): iclass = ClJpr;
          FUNC_W'(FnJrl): iclass = ClJrl;
          FUNC_W'(FnWwd): iclass = ClWwd;
          FUNC_W'(FnHlt): iclass = ClHlt;
          FUNC_W'(FnEni): iclass = ClEni;
          FUNC_W'(FnDsi): iclass = ClDsi;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign alu_op = ALUOP_W'(alu_code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the TSC datapath.
// Sequences IF -> ID -> EX -> MEM -> WB, with a one-cycle INT step taken
// after a retiring instruction when interrupts are enabled and pending, and
// an absorbing HALT state.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   opcode, func        instruction register fields
//   mem_ready           memory completes the current request this cycle
//   br_cond             branch comparator result
//   irq                 level interrupt request
//   pc_write..is_halted 1-bit datapath strobes and status
//   pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op  datapath selects
module multicycle_control
  import tsc_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned FUNC_W   = 6,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned INT_EN   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                mem_ready,
  input  logic                br_cond,
  input  logic                irq,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic                epc_write,
  output logic                wwd_valid,
  output logic                inst_done,
  output logic                int_ack,
  output logic                ie,
  output logic                is_halted,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op
);

  localparam bit IntEnable = (INT_EN != 0);

  state_e              state_q, state_d;
  logic                ie_q, ie_d;
  logic                halted_q, halted_d;
  iclass_e             iclass;
  logic [ALUOP_W-1:0]  dec_alu_op;

  control_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNC_W   (FUNC_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .opcode (opcode),
    .func   (func),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    epc_write  = 1'b0;
    wwd_valid  = 1'b0;
    inst_done  = 1'b0;
    int_ack    = 1'b0;
    pc_src     = PcSrcNext;
    reg_dst    = RegDstRt;
    mem_to_reg = MemToRegAlu;
    alu_src_b  = AluSrcBReg;
    alu_op     = '0;

    // Strobes are suppressed while reset is held, even though state already reads IF.
    if (!reset) begin
      unique case (state_q)
        StIf: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PcSrcNext;
            state_d  = StId;
          end
        end
        StId: begin
          state_d = StEx;
          case (iclass)
            ClJmp, ClJpr: begin
              pc_write  = 1'b1;
              pc_src    = PcSrcJump;
              inst_done = 1'b1;
            end
            ClJal, ClJrl: begin
              pc_write   = 1'b1;
              pc_src     = PcSrcJump;
              reg_write  = 1'b1;
              reg_dst    = RegDstR2;
              mem_to_reg = MemToRegPc;
              inst_done  = 1'b1;
            end
            ClHlt: state_d = StHalt;
            ClEni: begin
              if (IntEnable) ie_d = 1'b1;
              inst_done = 1'b1;
            end
            ClDsi: begin
              ie_d      = 1'b0;
              inst_done = 1'b1;
            end
            ClNop: inst_done = 1'b1;
            default: ;
          endcase
        end
        StEx: begin
          alu_src_a = 1'b1;
          alu_op    = dec_alu_op;
          if (uses_imm(iclass)) alu_src_b = AluSrcBImm;
          case (iclass)
            ClBranch: begin
              if (br_cond) begin
                pc_write = 1'b1;
                pc_src   = PcSrcBranch;
              end
              inst_done = 1'b1;
            end
            ClLoad, ClStore: state_d = StMem;
            default:         state_d = StWb;
          endcase
        end
        StMem: begin
          i_or_d    = 1'b1;
          mem_read  = (iclass == ClLoad);
          mem_write = (iclass != ClLoad);
          if (mem_ready) begin
            if (iclass == ClLoad) state_d = StWb;
            else                  inst_done = 1'b1;
          end
        end
        StWb: begin
          if (iclass == ClWwd) begin
            wwd_valid = 1'b1;
          end else begin
            reg_write  = 1'b1;
            reg_dst    = (iclass == ClRalu) ? RegDstRd : RegDstRt;
            mem_to_reg = (iclass == ClLoad) ? MemToRegMem : MemToRegAlu;
          end
          inst_done = 1'b1;
        end
        StInt: begin
          epc_write = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PcSrcVector;
          int_ack   = 1'b1;
          ie_d      = 1'b0;
          state_d   = StIf;
        end
        StHalt: state_d = StHalt;
        default: state_d = StIf;
      endcase

      // The interrupt decision uses ie as it stood during the retiring cycle.
      if (inst_done) begin
        state_d = (IntEnable && ie_q && irq) ? StInt : StIf;
      end
    end

    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIf;
      ie_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      halted_q <= halted_d;
    end
  end

  assign ie        = ie_q;
  assign is_halted = halted_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic [5:0] func;
  logic       mem_ready, br_cond, irq;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a;
  logic       epc_write, wwd_valid, inst_done, int_ack, ie, is_halted;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W (4),
    .FUNC_W   (6),
    .ALUOP_W  (3),
    .INT_EN   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .func       (func),
    .mem_ready  (mem_ready),
    .br_cond    (br_cond),
    .irq        (irq),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .epc_write  (epc_write),
    .wwd_valid  (wwd_valid),
    .inst_done  (inst_done),
    .int_ack    (int_ack),
    .ie         (ie),
    .is_halted  (is_halted),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op)
  );

  typedef struct packed {
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a;
    logic       epc_write, wwd_valid, inst_done, int_ack, ie, is_halted;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0] alu_op;
  } outv_t;

  localparam int KNop = 0, KRalu = 1, KIalu = 2, KLwd = 3, KSwd = 4, KBr = 5, KJmp = 6;
  localparam int KJal = 7, KJpr = 8, KJrl = 9, KWwd = 10, KHlt = 11, KEni = 12, KDsi = 13;

  outv_t act, exp_v;
  logic  exp_valid = 1'b0;
  string tag = "";
  string cur_name = "";
  int    checks = 0, failures = 0, cyc_cnt = 0;
  int    n_done = 0, n_regw = 0, n_epc = 0, n_pcw = 0, n_memrd = 0;
  logic  m_ie = 1'b0, m_halted = 1'b0;
  int    fn_list [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28, 30, 31, 40};

  assign act = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a,
                epc_write, wwd_valid, inst_done, int_ack, ie, is_halted,
                pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op};

  // Per-cycle comparison against the model's expected output vector.
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL %s t=%0t actual=%b required=%b", tag, $time, act, exp_v);
      end
    end
    if (!reset) begin
      n_done  += int'(inst_done);
      n_regw  += int'(reg_write);
      n_epc   += int'(epc_write);
      n_pcw   += int'(pc_write);
      n_memrd += int'(mem_read && i_or_d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask

  function automatic outv_t base();
    outv_t e = '0;
    e.ie        = m_ie;
    e.is_halted = m_halted;
    return e;
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(1));
  endfunction

  function automatic logic irqd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  function automatic void classify(input int op, input int fn, output int kind,
                                   output logic [2:0] alu);
    kind = KNop;
    alu  = 3'd0;
    if (op <= 3) begin kind = KBr; alu = 3'd1; end
    else if (op == 4) kind = KIalu;
    else if (op == 5) begin kind = KIalu; alu = 3'd3; end
    else if (op == 6) begin kind = KIalu; alu = 3'd6; end
    else if (op == 7) kind = KLwd;
    else if (op == 8) kind = KSwd;
    else if (op == 9) kind = KJmp;
    else if (op == 10) kind = KJal;
    else if (op == 15) begin
      if (fn <= 7) begin kind = KRalu; alu = 3'(fn); end
      else if (fn == 25) kind = KJpr;
      else if (fn == 26) kind = KJrl;
      else if (fn == 28) kind = KWwd;
      else if (fn == 29) kind = KHlt;
      else if (fn == 30) kind = KEni;
      else if (fn == 31) kind = KDsi;
    end
  endfunction

  // Drive one cycle's inputs just after a rising edge and post its expectation.
  task automatic do_cycle(input logic mr, input logic bc, input logic iq, input outv_t e,
                          input string ph);
    mem_ready = mr;
    br_cond   = bc;
    irq       = iq;
    exp_v     = e;
    tag       = {cur_name, "/", ph};
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Run one instruction through its whole schedule; ncyc includes any INT step.
  task automatic run_inst(input int op, input int fn, input int w_if, input int w_mem,
                          input logic br, input int pct, output int ncyc);
    outv_t      e;
    int         kind, start;
    logic [2:0] alu;
    logic       fin, fmr, fbc, iq, take;
    start    = cyc_cnt;
    classify(op, fn, kind, alu);
    cur_name = $sformatf("op%0d.fn%0d", op, fn);
    opcode   = 4'(op);
    func     = 6'(fn);
    for (int i = 0; i < w_if; i++) begin
      e = base(); e.mem_read = 1'b1;
      do_cycle(1'b0, rnd(), irqd(pct), e, "if_wait");
    end
    e = base(); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd0;
    do_cycle(1'b1, rnd(), irqd(pct), e, "if");

    e   = base();
    fin = 1'b1;
    fmr = rnd();
    fbc = rnd();
    case (kind)
      KJmp, KJpr: begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
      KJal, KJrl: begin
        e.pc_write = 1'b1; e.pc_src = 2'd2;
        e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
      end
      KEni, KDsi, KNop, KHlt: ;
      default: fin = 1'b0;
    endcase

    if (kind == KHlt) begin
      do_cycle(rnd(), rnd(), irqd(pct), e, "id_hlt");
      m_halted = 1'b1;
    end else begin
      if (!fin) begin
        do_cycle(rnd(), rnd(), irqd(pct), e, "id");
        e = base(); e.alu_src_a = 1'b1; e.alu_op = alu;
        if (kind == KIalu || kind == KLwd || kind == KSwd) e.alu_src_b = 2'd1;
        if (kind == KBr) begin
          fin = 1'b1;
          fbc = br;
          if (br) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
        end else begin
          do_cycle(rnd(), rnd(), irqd(pct), e, "ex");
        end
      end
      if (!fin && (kind == KLwd || kind == KSwd)) begin
        e = base(); e.i_or_d = 1'b1;
        e.mem_read  = (kind == KLwd);
        e.mem_write = (kind == KSwd);
        for (int i = 0; i < w_mem; i++) do_cycle(1'b0, rnd(), irqd(pct), e, "mem_wait");
        if (kind == KSwd) begin
          fin = 1'b1;
          fmr = 1'b1;
        end else begin
          do_cycle(1'b1, rnd(), irqd(pct), e, "mem");
        end
      end
      if (!fin) begin
        e = base();
        if (kind == KWwd) begin
          e.wwd_valid = 1'b1;
        end else begin
          e.reg_write  = 1'b1;
          e.reg_dst    = (kind == KRalu) ? 2'd1 : 2'd0;
          e.mem_to_reg = (kind == KLwd) ? 2'd1 : 2'd0;
        end
      end
      e.inst_done = 1'b1;
      iq = irqd(pct);
      do_cycle(fmr, fbc, iq, e, "retire");
      take = m_ie && iq;
      if (kind == KEni) m_ie = 1'b1;
      else if (kind == KDsi) m_ie = 1'b0;
      if (take) begin
        e = base(); e.epc_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd3; e.int_ack = 1'b1;
        do_cycle(rnd(), rnd(), irqd(pct), e, "int");
        m_ie = 1'b0;
      end
    end
    ncyc = cyc_cnt - start;
  endtask

  initial begin
    int    nc, d0, d1, d2;
    outv_t e;
    reset = 1'b1; mem_ready = 1'b0; br_cond = 1'b0; irq = 1'b0; opcode = '0; func = '0;
    repeat (2) @(posedge clk);
    #1;
    cur_name = "reset";
    do_cycle(1'b1, 1'b1, 1'b1, outv_t'('0), "held");
    reset = 1'b0;

    // ADD, zero wait: four cycles, one register write, one retire.
    d0 = n_regw; d1 = n_done;
    run_inst(15, 0, 0, 0, 1'b0, 0, nc);
    check_eq("add_cycles", nc, 4);
    check_eq("add_regw", n_regw - d0, 1);
    check_eq("add_done", n_done - d1, 1);

    // LWD with three wait cycles in MEM.
    d0 = n_memrd;
    run_inst(7, 0, 0, 3, 1'b0, 0, nc);
    check_eq("lwd_cycles", nc, 8);
    check_eq("lwd_memrd", n_memrd - d0, 4);

    // SWD: no register write.
    d0 = n_regw;
    run_inst(8, 0, 1, 0, 1'b0, 0, nc);
    check_eq("swd_cycles", nc, 5);
    check_eq("swd_regw", n_regw - d0, 0);

    // BEQ not taken then taken.
    d0 = n_pcw;
    run_inst(1, 0, 0, 0, 1'b0, 0, nc);
    check_eq("beq0_cycles", nc, 3);
    check_eq("beq0_pcw", n_pcw - d0, 1);
    d0 = n_pcw;
    run_inst(1, 0, 0, 0, 1'b1, 0, nc);
    check_eq("beq1_cycles", nc, 3);
    check_eq("beq1_pcw", n_pcw - d0, 2);

    // ENI then ADD with irq high: interrupt after the ADD retires.
    run_inst(15, 30, 0, 0, 1'b0, 0, nc);
    check_eq("eni_cycles", nc, 2);
    d0 = n_epc;
    run_inst(15, 0, 0, 0, 1'b0, 100, nc);
    check_eq("add_int_cycles", nc, 5);
    check_eq("add_int_epc", n_epc - d0, 1);
    // ie is now clear: irq must be ignored.
    d0 = n_epc;
    run_inst(15, 0, 0, 0, 1'b0, 100, nc);
    check_eq("add_noint_cycles", nc, 4);
    check_eq("add_noint_epc", n_epc - d0, 0);

    // Randomized instruction stream.
    for (int k = 0; k < 300; k++) begin
      int op, fn;
      if ($urandom_range(1) == 0) begin
        op = $urandom_range(14);
        fn = $urandom_range(63);
      end else begin
        op = 15;
        fn = fn_list[$urandom_range(13)];
      end
      run_inst(op, fn, $urandom_range(2), $urandom_range(3), rnd(), 20, nc);
    end

    // Reset in the middle of a load's memory wait.
    cur_name = "rst_mem";
    opcode = 4'd7; func = 6'd0;
    e = base(); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    do_cycle(1'b1, 1'b0, 1'b0, e, "if");
    e = base();
    do_cycle(1'b0, 1'b0, 1'b0, e, "id");
    e = base(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd1;
    do_cycle(1'b0, 1'b0, 1'b0, e, "ex");
    e = base(); e.mem_read = 1'b1; e.i_or_d = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b0, e, "mem_wait");
    mem_ready = 1'b0;
    #1;
    reset = 1'b1;
    exp_v = '0;
    tag   = "rst_mem/asserted";
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ie = 1'b0; m_halted = 1'b0;
    run_inst(15, 0, 0, 0, 1'b0, 0, nc);
    check_eq("post_reset_add_cycles", nc, 4);

    // HLT with ie set: absorbing, irq has no effect.
    run_inst(15, 30, 0, 0, 1'b0, 0, nc);
    d0 = n_pcw; d1 = n_done; d2 = n_epc;
    run_inst(15, 29, 0, 0, 1'b0, 0, nc);
    check_eq("hlt_cycles", nc, 2);
    cur_name = "halted";
    for (int i = 0; i < 20; i++) do_cycle(rnd(), rnd(), 1'b1, base(), "idle");
    check_eq("halt_pcw", n_pcw - d0, 1);
    check_eq("halt_done", n_done - d1, 0);
    check_eq("halt_epc", n_epc - d2, 0);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
